// File: rtl/cocobus_arbiter.sv
// Hands the cartridge memory bus between the CoCo and the AVR: halt, quiet check, grant, release.
// All outputs are registered and follow the next state, so they change on the same edge as the state.
module cocobus_arbiter #(
  parameter int HALT_WAIT    = 3,
  parameter int QUIET_CYCLES = 2,
  parameter int RETRY_LIMIT  = 4,
  parameter int RELEASE_HOLD = 2,
  parameter int CNT_W        = 4
) (
  input  logic       eclk,
  input  logic       reset,
  input  logic       c_power,
  input  logic       a_power,
  input  logic       a_brpin,
  input  logic       cts_n,
  input  logic       scs_n,
  input  logic       c_rw,
  input  logic       a_regack,
  output logic       halt_oe,
  output logic       a_busmaster,
  output logic       a_grant_err,
  output logic       a_regint,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HALT    = 3'd1,
    ST_CHECK   = 3'd2,
    ST_GRANT   = 3'd3,
    ST_RELEASE = 3'd4,
    ST_ERROR   = 3'd5,
    ST_OFF     = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] HALT_LAST   = CNT_W'(HALT_WAIT - 1);
  localparam logic [CNT_W-1:0] QUIET_LAST  = CNT_W'(QUIET_CYCLES - 1);
  localparam logic [CNT_W-1:0] RETRY_LAST  = CNT_W'(RETRY_LIMIT - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_HOLD - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] retry_q, retry_d;
  logic             halt_oe_q, halt_oe_d;
  logic             busmaster_q, busmaster_d;
  logic             grant_err_q, grant_err_d;
  logic             regint_q, regint_d;

  logic a_busreq;
  logic bus_quiet;
  logic reg_write;

  assign a_busreq  = a_power & a_brpin;
  assign bus_quiet = cts_n & scs_n;
  assign reg_write = ~scs_n & ~c_rw & c_power & ~busmaster_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  always_ff @(posedge eclk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= CNT_ZERO;
      retry_q     <= CNT_ZERO;
      halt_oe_q   <= 1'b0;
      busmaster_q <= 1'b0;
      grant_err_q <= 1'b0;
      regint_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      halt_oe_q   <= halt_oe_d;
      busmaster_q <= busmaster_d;
      grant_err_q <= grant_err_d;
      regint_q    <= regint_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;

    case (state_q)
      ST_IDLE: begin
        if (a_busreq) begin
          state_d = ST_HALT;
          cnt_d   = CNT_ZERO;
          retry_d = CNT_ZERO;
        end
      end
      ST_HALT: begin
        if (!a_busreq) begin
          state_d = ST_RELEASE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == HALT_LAST) begin
          state_d = ST_CHECK;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      ST_CHECK: begin
        if (!a_busreq) begin
          state_d = ST_RELEASE;
          cnt_d   = CNT_ZERO;
        end else if (bus_quiet) begin
          if (cnt_q == QUIET_LAST) begin
            state_d = ST_GRANT;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end else begin
          // A select seen mid-window restarts the quiet count and burns a retry.
          cnt_d = CNT_ZERO;
          if (retry_q == RETRY_LAST) begin
            state_d = ST_ERROR;
          end else begin
            retry_d = sat_inc(retry_q);
          end
        end
      end
      ST_GRANT: begin
        if (!a_busreq) begin
          state_d = ST_RELEASE;
          cnt_d   = CNT_ZERO;
        end
      end
      ST_RELEASE: begin
        if (cnt_q == RELEASE_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      ST_ERROR: begin
        if (!a_busreq) begin
          state_d = ST_IDLE;
        end
      end
      ST_OFF: begin
        if (c_power) begin
          state_d = a_busreq ? ST_GRANT : ST_IDLE;
          cnt_d   = CNT_ZERO;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
        retry_d = CNT_ZERO;
      end
    endcase

    if (!c_power) begin
      state_d = ST_OFF;
      cnt_d   = CNT_ZERO;
    end
  end

  always_comb begin
    halt_oe_d   = 1'b0;
    busmaster_d = 1'b0;
    grant_err_d = 1'b0;
    case (state_d)
      ST_HALT, ST_CHECK, ST_RELEASE: halt_oe_d = 1'b1;
      ST_GRANT: begin
        halt_oe_d   = 1'b1;
        busmaster_d = 1'b1;
      end
      ST_ERROR: grant_err_d = 1'b1;
      ST_OFF:   busmaster_d = 1'b1;
      default: begin
        halt_oe_d   = 1'b0;
        busmaster_d = 1'b0;
      end
    endcase
  end

  // Set beats ack so a write landing on the ack cycle is never lost.
  assign regint_d = reg_write | (regint_q & ~a_regack);

  assign halt_oe     = halt_oe_q;
  assign a_busmaster = busmaster_q;
  assign a_grant_err = grant_err_q;
  assign a_regint    = regint_q;
  assign state       = state_q;

endmodule
